// File: rtl/data_sync_rx_pkg.sv
// data_sync_rx_pkg: shared FSM encoding and synchroniser depth limit for the toggle-handshake CDC receiver
package data_sync_rx_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam int MIN_STAGES = 2;
endpackage

// File: rtl/data_sync_rx_if.sv
// data_sync_rx_if: request/data/handshake bundle between the CDC receiver and its source and consumer
interface data_sync_rx_if #(parameter int BUS_WIDTH = 8);
  logic                 DSYNC_REQ_TGL;
  logic [BUS_WIDTH-1:0] DSYNC_BUS_IN;
  logic                 DSYNC_READY;
  logic                 DSYNC_VALID;
  logic [BUS_WIDTH-1:0] DSYNC_BUS_OUT;
  logic                 DSYNC_PULSE;
  logic                 DSYNC_ACK_TGL;
  logic                 DSYNC_OVERRUN;
  modport master (
    output DSYNC_REQ_TGL, DSYNC_BUS_IN, DSYNC_READY,
    input  DSYNC_VALID, DSYNC_BUS_OUT, DSYNC_PULSE, DSYNC_ACK_TGL, DSYNC_OVERRUN
  );
  modport slave (
    input  DSYNC_REQ_TGL, DSYNC_BUS_IN, DSYNC_READY,
    output DSYNC_VALID, DSYNC_BUS_OUT, DSYNC_PULSE, DSYNC_ACK_TGL, DSYNC_OVERRUN
  );
endinterface

// File: rtl/data_sync_rx_bit_sync.sv
// data_sync_rx_bit_sync: STAGES-deep single-bit synchroniser, async active-low reset to 0
module data_sync_rx_bit_sync #(parameter int STAGES = 2) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[STAGES-2:0], d};
  assign q = sync[STAGES-1];
endmodule

// File: rtl/data_sync_rx.sv
// data_sync_rx: toggle-handshake CDC receiver; captures the source word on each synchronised request edge
module data_sync_rx
  import data_sync_rx_pkg::*;
#(
  parameter int STAGES    = 2,
  parameter int BUS_WIDTH = 8
) (
  input logic           DSYNC_CLK,
  input logic           DSYNC_RST,
  data_sync_rx_if.slave dsync
);
  logic                 req_sync, req_prev, req_edge;
  logic [0:0]           state;
  logic                 valid, pulse, ack_tgl, overrun;
  logic [BUS_WIDTH-1:0] bus_out;
  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("data_sync_rx: STAGES must be at least %0d", MIN_STAGES);
  end
  data_sync_rx_bit_sync #(.STAGES(STAGES)) u_req_sync (
    .clk  (DSYNC_CLK),
    .rst_n(DSYNC_RST),
    .d    (dsync.DSYNC_REQ_TGL),
    .q    (req_sync)
  );
  assign req_edge = req_sync ^ req_prev;
  // a request edge seen in HOLD is consumed and its word dropped, even on the accepting cycle
  always_ff @(posedge DSYNC_CLK or negedge DSYNC_RST)
    if (!DSYNC_RST) begin
      req_prev <= 1'b0;
      state    <= ST_IDLE;
      valid    <= 1'b0;
      pulse    <= 1'b0;
      ack_tgl  <= 1'b0;
      overrun  <= 1'b0;
      bus_out  <= '0;
    end else begin
      req_prev <= req_sync;
      pulse    <= 1'b0;
      if (state == ST_IDLE) begin
        if (req_edge) begin
          bus_out <= dsync.DSYNC_BUS_IN;
          valid   <= 1'b1;
          pulse   <= 1'b1;
          state   <= ST_HOLD;
        end
      end else begin
        if (req_edge) overrun <= 1'b1;
        if (valid && dsync.DSYNC_READY) begin
          valid   <= 1'b0;
          ack_tgl <= ~ack_tgl;
          state   <= ST_IDLE;
        end
      end
    end
  assign dsync.DSYNC_VALID   = valid;
  assign dsync.DSYNC_BUS_OUT = bus_out;
  assign dsync.DSYNC_PULSE   = pulse;
  assign dsync.DSYNC_ACK_TGL = ack_tgl;
  assign dsync.DSYNC_OVERRUN = overrun;
endmodule

// File: tb/tb_data_sync_rx.sv
// tb_data_sync_rx: directed self-checking bench for the toggle-handshake CDC receiver
module tb_data_sync_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   pulse_cnt = 0;
  logic [11:0] obs;
  data_sync_rx_if #(.BUS_WIDTH(8)) dif ();
  data_sync_rx #(.STAGES(2), .BUS_WIDTH(8)) dut (
    .DSYNC_CLK(clk),
    .DSYNC_RST(rst_n),
    .dsync    (dif)
  );
  always #5 clk = ~clk;
  // observed word: {valid, pulse, ack, overrun, bus_out[7:0]}
  assign obs = {dif.DSYNC_VALID, dif.DSYNC_PULSE, dif.DSYNC_ACK_TGL, dif.DSYNC_OVERRUN, dif.DSYNC_BUS_OUT};
  always @(negedge clk) if (dif.DSYNC_PULSE === 1'b1) pulse_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] data);
    dif.DSYNC_BUS_IN = data;
    dif.DSYNC_REQ_TGL = ~dif.DSYNC_REQ_TGL;
  endtask

  task automatic test_reset;
    dif.DSYNC_REQ_TGL = 1'($urandom);
    dif.DSYNC_BUS_IN = 8'($urandom);
    dif.DSYNC_READY = 1'($urandom);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, 12'h000); end
    dif.DSYNC_REQ_TGL = 1'($urandom);
    dif.DSYNC_BUS_IN = 8'($urandom);
    tick(2);
    dif.DSYNC_REQ_TGL = 1'b0;
    dif.DSYNC_READY = 1'b0;
    rst_n = 1'b1;
    tick(1);
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, 12'h000); end
  endtask

  task automatic test_single;
    dif.DSYNC_READY = 1'b1;
    send(8'hA5);
    tick(2);
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL single_latency: got %h expected %h", obs, 12'h000); end
    tick(1);
    checks++; if (obs !== 12'hCA5) begin errors++; $display("FAIL single_capture: got %h expected %h", obs, 12'hCA5); end
    tick(1);
    checks++; if (obs !== 12'h2A5) begin errors++; $display("FAIL single_accept: got %h expected %h", obs, 12'h2A5); end
    tick(1);
    checks++; if (obs !== 12'h2A5) begin errors++; $display("FAIL single_idle: got %h expected %h", obs, 12'h2A5); end
  endtask

  task automatic test_back_to_back;
    send(8'h3C);
    tick(3);
    checks++; if (obs !== 12'hE3C) begin errors++; $display("FAIL b2b_capture: got %h expected %h", obs, 12'hE3C); end
    tick(1);
    checks++; if (obs !== 12'h03C) begin errors++; $display("FAIL b2b_accept: got %h expected %h", obs, 12'h03C); end
  endtask

  task automatic test_backpressure;
    dif.DSYNC_READY = 1'b0;
    send(8'hA5);
    tick(3);
    checks++; if (obs !== 12'hCA5) begin errors++; $display("FAIL bp_capture: got %h expected %h", obs, 12'hCA5); end
    dif.DSYNC_BUS_IN = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++; if (obs !== 12'h8A5) begin errors++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, obs, 12'h8A5); end
    end
    dif.DSYNC_READY = 1'b1;
    tick(1);
    checks++; if (obs !== 12'h2A5) begin errors++; $display("FAIL bp_release: got %h expected %h", obs, 12'h2A5); end
  endtask

  task automatic test_overrun;
    dif.DSYNC_READY = 1'b0;
    pulse_cnt = 0;
    send(8'h5A);
    tick(3);
    checks++; if (obs !== 12'hE5A) begin errors++; $display("FAIL ovr_capture: got %h expected %h", obs, 12'hE5A); end
    send(8'h77);
    tick(4);
    checks++; if (obs !== 12'hB5A) begin errors++; $display("FAIL ovr_first: got %h expected %h", obs, 12'hB5A); end
    send(8'h78);
    tick(4);
    checks++; if (obs !== 12'hB5A) begin errors++; $display("FAIL ovr_second: got %h expected %h", obs, 12'hB5A); end
    dif.DSYNC_READY = 1'b1;
    tick(1);
    checks++; if (obs !== 12'h15A) begin errors++; $display("FAIL ovr_accept: got %h expected %h", obs, 12'h15A); end
    tick(3);
    checks++; if (obs !== 12'h15A) begin errors++; $display("FAIL ovr_sticky: got %h expected %h", obs, 12'h15A); end
    checks++; if (pulse_cnt !== 1) begin errors++; $display("FAIL ovr_valid_count: got %0d expected %0d", pulse_cnt, 1); end
  endtask

  task automatic test_reset_mid_hold;
    dif.DSYNC_READY = 1'b1;
    send(8'h11);
    tick(4);
    checks++; if (obs !== 12'h311) begin errors++; $display("FAIL rmh_pre: got %h expected %h", obs, 12'h311); end
    dif.DSYNC_READY = 1'b0;
    send(8'h22);
    tick(3);
    checks++; if (obs !== 12'hF22) begin errors++; $display("FAIL rmh_capture: got %h expected %h", obs, 12'hF22); end
    tick(1);
    checks++; if (obs !== 12'hB22) begin errors++; $display("FAIL rmh_hold: got %h expected %h", obs, 12'hB22); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL rmh_async: got %h expected %h", obs, 12'h000); end
    dif.DSYNC_REQ_TGL = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++; if (obs !== 12'h000) begin errors++; $display("FAIL rmh_no_capture[%0d]: got %h expected %h", i, obs, 12'h000); end
    end
  endtask

  task automatic test_overrun_on_accept;
    dif.DSYNC_READY = 1'b0;
    send(8'h99);
    tick(3);
    checks++; if (obs !== 12'hC99) begin errors++; $display("FAIL oa_capture: got %h expected %h", obs, 12'hC99); end
    send(8'h66);
    tick(2);
    checks++; if (obs !== 12'h899) begin errors++; $display("FAIL oa_hold: got %h expected %h", obs, 12'h899); end
    dif.DSYNC_READY = 1'b1;
    tick(1);
    checks++; if (obs !== 12'h399) begin errors++; $display("FAIL oa_accept: got %h expected %h", obs, 12'h399); end
    tick(4);
    checks++; if (obs !== 12'h399) begin errors++; $display("FAIL oa_dropped: got %h expected %h", obs, 12'h399); end
  endtask

  initial begin
    dif.DSYNC_REQ_TGL = 1'b0;
    dif.DSYNC_BUS_IN = 8'h00;
    dif.DSYNC_READY = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_overrun;
    test_reset_mid_hold;
    test_overrun_on_accept;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_sync_rx.md
# data_sync_rx

Destination-side receiver for a toggle-request/toggle-acknowledge multi-bit clock-domain crossing. The block synchronises an asynchronous request toggle through a parameterised flop chain and captures the unsynchronised source bus on the detected edge. It then presents the captured word to a local consumer under a valid/ready handshake and returns an acknowledge toggle to the source domain only after the consumer accepts. It sits at the receiving edge of every multi-bit crossing in the system, for example between the UART and the system-clock domains.

## Interface

- STAGES, 2, number of request synchroniser flops; legal values ≥ 2.
- BUS_WIDTH, 8, width of the crossing data word.

- DSYNC_CLK  in  1  destination-domain clock; all state is rising-edge triggered.
- DSYNC_RST  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- DSYNC_REQ_TGL  in  1  request toggle from the source domain; asynchronous to DSYNC_CLK; each transition is one request.
- DSYNC_BUS_IN  in  BUS_WIDTH  source data word; not synchronised; the source holds it stable from its request toggle until it sees the acknowledge toggle.
- DSYNC_READY  in  1  consumer ready.
- DSYNC_VALID  out  1  captured word available.
- DSYNC_BUS_OUT  out  BUS_WIDTH  captured word; stable while DSYNC_VALID=1.
- DSYNC_PULSE  out  1  single-cycle strobe in the first cycle of each DSYNC_VALID assertion.
- DSYNC_ACK_TGL  out  1  registered acknowledge toggle returned to the source domain.
- DSYNC_OVERRUN  out  1  sticky protocol-violation flag.

## Operation

- Reset (DSYNC_RST=0): synchroniser flops, REQ_PREV, DSYNC_ACK_TGL, DSYNC_VALID, DSYNC_PULSE, DSYNC_BUS_OUT, and DSYNC_OVERRUN all go to 0; the state machine goes to IDLE. Assertion takes effect immediately, with no clock required.
- Request synchronisation: DSYNC_REQ_TGL feeds SYNC[0] through SYNC[STAGES-1]. REQ_PREV registers SYNC[STAGES-1]. REQ_EDGE = SYNC[STAGES-1] XOR REQ_PREV, which is combinational.
- FSM, two states:
  - IDLE: when REQ_EDGE=1, register DSYNC_BUS_OUT←DSYNC_BUS_IN, DSYNC_VALID←1, DSYNC_PULSE←1, and move to HOLD.
  - HOLD: DSYNC_PULSE←0. When DSYNC_VALID & DSYNC_READY, set DSYNC_VALID←0, invert DSYNC_ACK_TGL, and move to IDLE.
- Overrun: REQ_EDGE=1 while in HOLD sets DSYNC_OVERRUN←1.
  - The edge is consumed and its data dropped.
  - DSYNC_BUS_OUT is unchanged.
  - This applies even when the accept happens in the same cycle.
  - DSYNC_OVERRUN clears only on reset.
- DSYNC_BUS_OUT is written only on the IDLE→HOLD transition. Changes on DSYNC_BUS_IN at any other time are ignored.
- Reset mid-transfer: the held word is discarded and DSYNC_ACK_TGL returns to 0. The source must be reset together with this block. If DSYNC_REQ_TGL is 1 at reset release, the block detects one edge and treats it as a legal request.

## Timing

- Request latency: if the toggle is first sampled at edge n (into SYNC[0]), then DSYNC_VALID, DSYNC_PULSE, and DSYNC_BUS_OUT update at edge n+STAGES. This is 2 cycles for STAGES=2.
- DSYNC_PULSE is high for exactly one cycle per capture.
- Accept: if DSYNC_READY=1 at the edge where DSYNC_VALID first becomes 1, it is sampled at the next edge. The acceptance edge clears DSYNC_VALID and toggles DSYNC_ACK_TGL together.
- DSYNC_VALID may stay high indefinitely. While it is high, DSYNC_BUS_OUT and DSYNC_ACK_TGL are constant.
- All outputs are registered, with no combinational path from inputs to outputs.
- Throughput: at most one word per source round trip (request sync + accept + acknowledge sync in the source domain).

## Structure

- Shared package: FSM state encoding (IDLE=1'b0, HOLD=1'b1) and the minimum-STAGES constant (2).
- One sub-module, bit_sync: a STAGES-deep single-bit synchroniser with asynchronous active-low reset to 0. It is used for the request path and is reusable by the source-side transmitter for the acknowledge path.
- The top level holds REQ_PREV, the FSM, the capture register, and the acknowledge/overrun flops.

## Test plan

- Reset: assert DSYNC_RST with random inputs → all outputs 0 immediately and in the first cycle after release.
- Single transfer (STAGES=2): DSYNC_BUS_IN=0xA5, DSYNC_REQ_TGL 0→1 sampled at edge 1, DSYNC_READY=1 → at edge 3 DSYNC_VALID=1, DSYNC_PULSE=1 for one cycle, DSYNC_BUS_OUT=0xA5 → at edge 4 DSYNC_VALID=0 and DSYNC_ACK_TGL=1.
- Backpressure: same as above with DSYNC_READY=0 for 10 cycles and DSYNC_BUS_IN changed to 0xFF → DSYNC_VALID stays 1, DSYNC_BUS_OUT stays 0xA5, DSYNC_ACK_TGL stays 0, DSYNC_PULSE stays 0 after the first cycle. Raising DSYNC_READY completes the transfer.
- Back-to-back: after DSYNC_ACK_TGL=1, send 0x3C with DSYNC_REQ_TGL 1→0 → capture 0x3C, DSYNC_ACK_TGL returns to 0, DSYNC_OVERRUN=0.
- Overrun: toggle DSYNC_REQ_TGL twice while in HOLD with DSYNC_READY=0 → DSYNC_OVERRUN=1 and sticky, DSYNC_BUS_OUT unchanged, exactly one DSYNC_VALID assertion in total.
- Reset mid-HOLD: drop DSYNC_RST between clock edges → DSYNC_VALID and DSYNC_ACK_TGL go to 0 asynchronously, and no capture occurs after release while DSYNC_REQ_TGL=0.
